// File: rtl/fetch_sequencer.sv
// fetch_sequencer: sequences instruction fetches against a multi-cycle instruction memory.
//   clk         - system clock, rising edge
//   rst         - asynchronous active-low reset
//   branchTaken - EXE branch resolved taken this cycle
//   hazard      - hazard unit requests IF/ID hold
//   mem_stall   - MEM stage stall, freezes the whole pipeline
//   imem_ready  - one-cycle pulse, instruction word valid on memory output
//   freeze      - 1 holds the PC, 0 lets it load PC+4 or the branch target
//   flush       - clears IF/ID and ID/EXE
//   imem_req    - one-cycle pulse, memory latches the PC at this edge
//   if_valid    - fetched word is captured into IF/ID this cycle
//   imem_err    - sticky watchdog-expiry flag
//   stall_count - saturating count of frozen cycles since reset
module fetch_sequencer #(
    parameter int BOOT_CYCLES = 4,
    parameter int TIMEOUT     = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branchTaken,
    input  logic             hazard,
    input  logic             mem_stall,
    input  logic             imem_ready,
    output logic             freeze,
    output logic             flush,
    output logic             imem_req,
    output logic             if_valid,
    output logic             imem_err,
    output logic [CNT_W-1:0] stall_count
);
    localparam int BW = $clog2(BOOT_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {BOOT, ISSUE, WAIT, DISCARD, HOLD} state_t;

    state_t          state, nextState;
    logic [BW-1:0]   bootCnt;
    logic [WW-1:0]   wdCnt;
    logic            br, wdDone, timedOut;

    // A stalled EXE stage re-presents its branch, so it only counts once MEM lets go.
    assign br       = branchTaken & ~mem_stall;
    assign flush    = br && state != BOOT;
    assign imem_req = state == ISSUE;
    assign wdDone   = wdCnt == WW'(TIMEOUT - 1);

    // Outputs depend on this cycle's inputs so a branch redirects the PC immediately.
    always_comb begin
        nextState = state;
        freeze    = 1'b1;
        if_valid  = 1'b0;
        timedOut  = 1'b0;
        case (state)
            BOOT: nextState = bootCnt == BW'(BOOT_CYCLES - 1) ? ISSUE : BOOT;
            ISSUE: begin
                // A branch here means the request just issued used the old PC.
                freeze    = ~br;
                nextState = br ? DISCARD : WAIT;
            end
            WAIT: begin
                if (br) begin
                    freeze    = 1'b0;
                    nextState = imem_ready ? ISSUE : DISCARD;
                end else if (imem_ready) begin
                    if (hazard | mem_stall) nextState = HOLD;
                    else begin
                        if_valid  = 1'b1;
                        freeze    = 1'b0;
                        nextState = ISSUE;
                    end
                end else if (wdDone) begin
                    timedOut  = 1'b1;
                    nextState = ISSUE;
                end
            end
            DISCARD: begin
                freeze = ~br;
                if (imem_ready) nextState = ISSUE;
                else if (wdDone) begin
                    timedOut  = 1'b1;
                    nextState = ISSUE;
                end
            end
            HOLD: begin
                // The memory keeps the word stable until the next request, so it can wait here.
                if (br) begin
                    freeze    = 1'b0;
                    nextState = ISSUE;
                end else if (!(hazard | mem_stall)) begin
                    if_valid  = 1'b1;
                    freeze    = 1'b0;
                    nextState = ISSUE;
                end
            end
            default: nextState = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BOOT;
            bootCnt     <= '0;
            wdCnt       <= '0;
            imem_err    <= 1'b0;
            stall_count <= '0;
        end else begin
            state   <= nextState;
            bootCnt <= state == BOOT ? bootCnt + 1'b1 : bootCnt;
            // Restarts on every state change, so it measures time spent in the current state.
            wdCnt   <= nextState != state ? '0 : wdCnt + 1'b1;
            if (timedOut) imem_err <= 1'b1;
            if (state != BOOT && freeze && stall_count != '1) stall_count <= stall_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed-vector bench for fetch_sequencer.
module tb_fetch_sequencer;
    logic        clk = 1'b0, rst = 1'b0;
    logic        branchTaken = 1'b0, hazard = 1'b0, mem_stall = 1'b0, imem_ready = 1'b0;
    logic        freeze, flush, imem_req, if_valid, imem_err;
    logic [15:0] stall_count;
    logic        satFreeze, satFlush, satReq, satValid, satErr;
    logic [2:0]  satCount;
    logic [23:0] obs, expv;
    int          vectors = 0, miscompares = 0, expSc = 0;
    logic        expErr = 1'b0;

    always #5 clk = ~clk;

    fetch_sequencer #(.BOOT_CYCLES(4), .TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .branchTaken(branchTaken), .hazard(hazard), .mem_stall(mem_stall),
        .imem_ready(imem_ready), .freeze(freeze), .flush(flush), .imem_req(imem_req),
        .if_valid(if_valid), .imem_err(imem_err), .stall_count(stall_count)
    );

    fetch_sequencer #(.BOOT_CYCLES(4), .TIMEOUT(8), .CNT_W(3)) dutSat (
        .clk(clk), .rst(rst), .branchTaken(branchTaken), .hazard(hazard), .mem_stall(mem_stall),
        .imem_ready(imem_ready), .freeze(satFreeze), .flush(satFlush), .imem_req(satReq),
        .if_valid(satValid), .imem_err(satErr), .stall_count(satCount)
    );

    assign obs = {freeze, flush, imem_req, if_valid, imem_err, stall_count, satCount};

    function automatic logic [23:0] expected(input logic [3:0] outs);
        return {outs, expErr, 16'(expSc), 3'(expSc > 7 ? 7 : expSc)};
    endfunction

    task automatic drive(input logic [3:0] in);
        @(negedge clk);
        {branchTaken, hazard, mem_stall, imem_ready} = in;
        #1;
    endtask

    task automatic release_rst(input logic [3:0] in);
        @(negedge clk);
        rst = 1'b1;
        {branchTaken, hazard, mem_stall, imem_ready} = in;
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            drive(4'b1111);
            vectors++;
            expv = {4'b1000, 1'b0, 16'd0, 3'd0};
            if (obs !== expv) begin
                $display("FAIL reset[%0d] got %b required %b", i, obs, expv);
                miscompares++;
            end
        end
    endtask

    task automatic test_boot_fetch;
        logic [7:0] v [13] = '{8'b0000_1000, 8'b0000_1000, 8'b1111_1000, 8'b0000_1000,
                               8'b0000_1010, 8'b0000_1000, 8'b0001_0001,
                               8'b0000_1010, 8'b0000_1000, 8'b0001_0001,
                               8'b0000_1010, 8'b0000_1000, 8'b0001_0001};
        for (int i = 0; i < 13; i++) begin
            if (i == 0) release_rst(v[i][7:4]);
            else drive(v[i][7:4]);
            vectors++;
            expv = expected(v[i][3:0]);
            if (obs !== expv) begin
                $display("FAIL boot_fetch[%0d] got %b required %b", i, obs, expv);
                miscompares++;
            end
            if (i >= 4 && v[i][3]) expSc++;
        end
    endtask

    task automatic test_branch_discard;
        logic [7:0] v [13] = '{8'b0000_1010, 8'b1000_0100, 8'b0001_1000, 8'b0000_1010,
                               8'b0000_1000, 8'b0001_0001, 8'b1000_0110, 8'b1000_0100,
                               8'b0000_1000, 8'b0001_1000, 8'b0000_1010, 8'b1001_0100,
                               8'b0000_1010};
        for (int i = 0; i < 13; i++) begin
            drive(v[i][7:4]);
            vectors++;
            expv = expected(v[i][3:0]);
            if (obs !== expv) begin
                $display("FAIL branch_discard[%0d] got %b required %b", i, obs, expv);
                miscompares++;
            end
            if (v[i][3]) expSc++;
        end
    endtask

    task automatic test_hazard_hold;
        logic [7:0] v [9] = '{8'b0000_1000, 8'b0101_1000, 8'b0100_1000, 8'b0100_1000,
                              8'b0000_0001, 8'b0000_1010, 8'b0101_1000, 8'b1100_0100,
                              8'b0000_1010};
        for (int i = 0; i < 9; i++) begin
            drive(v[i][7:4]);
            vectors++;
            expv = expected(v[i][3:0]);
            if (obs !== expv) begin
                $display("FAIL hazard_hold[%0d] got %b required %b", i, obs, expv);
                miscompares++;
            end
            if (v[i][3]) expSc++;
        end
    endtask

    task automatic test_memstall_branch;
        logic [7:0] v [9] = '{8'b1010_1000, 8'b1010_1000, 8'b1000_0100, 8'b0001_1000,
                              8'b0000_1010, 8'b0011_1000, 8'b1010_1000, 8'b0000_0001,
                              8'b0000_1010};
        for (int i = 0; i < 9; i++) begin
            drive(v[i][7:4]);
            vectors++;
            expv = expected(v[i][3:0]);
            if (obs !== expv) begin
                $display("FAIL memstall_branch[%0d] got %b required %b", i, obs, expv);
                miscompares++;
            end
            if (v[i][3]) expSc++;
        end
    endtask

    task automatic test_timeout;
        logic [7:0] v [11] = '{8'b0000_1000, 8'b0000_1000, 8'b0000_1000, 8'b0000_1000,
                               8'b0000_1000, 8'b0000_1000, 8'b0000_1000, 8'b0000_1000,
                               8'b0000_1010, 8'b0001_0001, 8'b0000_1010};
        for (int i = 0; i < 11; i++) begin
            drive(v[i][7:4]);
            if (i == 8) expErr = 1'b1;
            vectors++;
            expv = expected(v[i][3:0]);
            if (obs !== expv) begin
                $display("FAIL timeout[%0d] got %b required %b", i, obs, expv);
                miscompares++;
            end
            if (v[i][3]) expSc++;
        end
    endtask

    task automatic test_reset_midwait;
        logic [7:0] v [6] = '{8'b0001_1000, 8'b0001_1000, 8'b1111_1000, 8'b0000_1000,
                              8'b0000_1010, 8'b0001_0001};
        drive(4'b0000);
        vectors++;
        expv = expected(4'b1000);
        if (obs !== expv) begin
            $display("FAIL midwait_pre got %b required %b", obs, expv);
            miscompares++;
        end
        #1 rst = 1'b0;
        imem_ready = 1'b1;
        #1;
        expSc = 0;
        expErr = 1'b0;
        vectors++;
        expv = expected(4'b1000);
        if (obs !== expv) begin
            $display("FAIL midwait_async got %b required %b", obs, expv);
            miscompares++;
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 0) release_rst(v[i][7:4]);
            else drive(v[i][7:4]);
            vectors++;
            expv = expected(v[i][3:0]);
            if (obs !== expv) begin
                $display("FAIL midwait_reboot[%0d] got %b required %b", i, obs, expv);
                miscompares++;
            end
            if (i >= 4 && v[i][3]) expSc++;
        end
    endtask

    initial begin
        test_reset;
        test_boot_fetch;
        test_branch_discard;
        test_hazard_hold;
        test_memstall_branch;
        test_timeout;
        test_reset_midwait;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
